det_rr_scheduler: RTL and testbench

//  Shares one two-step A-then-B sequence check between N_REQ requesters.
//  - Selects one requester by round-robin.
//  - Samples that requester's a, then its b, then reports a hit/miss result.
//  - Sits between requester ports and the shared detector datapath; only one check is in flight at a time.

---
 rtl/det_sched_pkg.sv | 19 +
 rtl/rr_pick.sv | 38 +++
 rtl/det_rr_scheduler.sv | 110 +++++++++++
 tb/tb_det_rr_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/det_sched_pkg.sv
// Shared types and defaults for the round-robin A-then-B detector scheduler.
package det_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SAMP_A = 2'b01,
    SAMP_B = 2'b10,
    REPORT = 2'b11
  } det_state_t;

  localparam int DET_N_REQ_DEF = 4;
  localparam int DET_CNT_W_DEF = 8;

  // Index width; kept at 1 so a single-requester build still has a real bus.
  function automatic int det_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, cyclic.
module rr_pick
  import det_sched_pkg::*;
#(
  parameter int N_REQ = DET_N_REQ_DEF,
  localparam int IW = det_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [IW-1:0] cand [N_REQ];

  // cand[gi] is the requester examined at priority position gi.
  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [IW:0] sum;
    assign sum      = {1'b0, ptr} + (IW+1)'(gi);
    assign cand[gi] = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : sum[IW-1:0];
  end

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[cand[i]]) begin
        any = 1'b1;
        idx = cand[i];
      end
    end
    gnt = '0;
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/det_rr_scheduler.sv
// Round-robin scheduler sharing one A-then-B sequence check between requesters.
// Optional saturating hit counter enabled by defining DET_HIT_CNT_EN.
module det_rr_scheduler
  import det_sched_pkg::*;
#(
  parameter int N_REQ = DET_N_REQ_DEF,
  parameter int CNT_W = DET_CNT_W_DEF,
  localparam int IW = det_idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] a,
  input  logic [N_REQ-1:0] b,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    owner,
  output logic             done,
  output logic             hit,
  output logic [1:0]       state_var
`ifdef DET_HIT_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_cnt
`endif
);

  det_state_t       state_reg, state_next;
  logic [N_REQ-1:0] gnt_reg;
  logic [IW-1:0]    owner_reg;
  logic [IW-1:0]    ptr_reg;
  logic             hit_reg;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req),
    .ptr (ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_any) state_next = SAMP_A;
      SAMP_A:  state_next = a[owner_reg] ? SAMP_B : REPORT;
      SAMP_B:  state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_reg   <= '0;
      owner_reg <= '0;
      ptr_reg   <= '0;
      hit_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            gnt_reg   <= pick_gnt;
            owner_reg <= pick_idx;
          end
        end
        SAMP_A: if (!a[owner_reg]) hit_reg <= 1'b0;
        SAMP_B: hit_reg <= b[owner_reg];
        REPORT: begin
          gnt_reg <= '0;
          // Step past the last owner so held requests rotate fairly.
          ptr_reg <= (owner_reg == IW'(N_REQ - 1)) ? '0 : owner_reg + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign owner     = owner_reg;
  assign hit       = hit_reg;
  assign done      = (state_reg == REPORT);
  assign state_var = state_reg;

`ifdef DET_HIT_CNT_EN
  logic [CNT_W-1:0] hit_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_reg <= '0;
    end else if (state_reg == REPORT && hit_reg && hit_cnt_reg != '1) begin
      hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
    end
  end

  assign hit_cnt = hit_cnt_reg;
`endif

  // Keeps CNT_W referenced when the counter is compiled out.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end

endmodule

// File: tb/tb_det_rr_scheduler.sv
// Directed self-checking bench for det_rr_scheduler (hit counter checked when DET_HIT_CNT_EN is set).
module tb_det_rr_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, a, b;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       done, hit;
  logic [1:0] state_var;
`ifdef DET_HIT_CNT_EN
  logic [1:0] hit_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  det_rr_scheduler #(.N_REQ(4), .CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .owner     (owner),
    .done      (done),
    .hit       (hit),
    .state_var (state_var)
`ifdef DET_HIT_CNT_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req = '0; a = '0; b = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_state", state_var, 2'b00);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_owner", owner, 2'd0);
    step(); step();
    reset = 1'b1;

    // Test 1: asynchronous reset in the middle of a transaction
    req = 4'b0001; a = 4'b0001; b = 4'b0001;
    step(); chk("t1_samp_a", state_var, 2'b01);
    step(); chk("t1_samp_b", state_var, 2'b10);
    #2 reset = 1'b0;
    #1;
    chk("t1_gnt", gnt, 4'b0000);
    chk("t1_done", done, 1'b0);
    chk("t1_hit", hit, 1'b0);
    chk("t1_state", state_var, 2'b00);
`ifdef DET_HIT_CNT_EN
    chk("t1_hit_cnt", hit_cnt, 2'd0);
`endif
    step();
    reset = 1'b1; req = '0;
    step();

    // Test 2: full hit on requester 0; req dropped after grant
    req = 4'b0001; a = 4'b0001; b = 4'b0001;
    step();
    $display("t2 txn: state=%b gnt=%b owner=%0d", state_var, gnt, owner);
    chk("t2_state_a", state_var, 2'b01);
    chk("t2_gnt_a", gnt, 4'b0001);
    chk("t2_done_a", done, 1'b0);
    req = '0;
    step();
    chk("t2_state_b", state_var, 2'b10);
    chk("t2_gnt_b", gnt, 4'b0001);
    step();
    chk("t2_state_r", state_var, 2'b11);
    chk("t2_done", done, 1'b1);
    chk("t2_hit", hit, 1'b1);
    chk("t2_owner", owner, 2'd0);
    chk("t2_gnt_r", gnt, 4'b0001);
    step();
    chk("t2_idle", state_var, 2'b00);
    chk("t2_gnt_idle", gnt, 4'b0000);
    chk("t2_done_idle", done, 1'b0);
`ifdef DET_HIT_CNT_EN
    chk("t2_hit_cnt", hit_cnt, 2'd1);
`endif

    // Test 3a: miss on a, skips SAMP_B
    req = 4'b0010; a = 4'b0000; b = 4'b1111;
    step();
    $display("t3a txn: state=%b owner=%0d", state_var, owner);
    chk("t3a_state_a", state_var, 2'b01);
    chk("t3a_owner", owner, 2'd1);
    req = '0;
    step();
    chk("t3a_state_r", state_var, 2'b11);
    chk("t3a_done", done, 1'b1);
    chk("t3a_hit", hit, 1'b0);
    step();
    chk("t3a_idle", state_var, 2'b00);

    // Test 3b: a seen, b missing
    req = 4'b0010; a = 4'b0010; b = 4'b1101;
    step();
    $display("t3b txn: state=%b owner=%0d", state_var, owner);
    chk("t3b_state_a", state_var, 2'b01);
    chk("t3b_owner", owner, 2'd1);
    req = '0;
    step(); chk("t3b_state_b", state_var, 2'b10);
    step();
    chk("t3b_state_r", state_var, 2'b11);
    chk("t3b_done", done, 1'b1);
    chk("t3b_hit", hit, 1'b0);
    step();
    chk("t3b_idle", state_var, 2'b00);
`ifdef DET_HIT_CNT_EN
    chk("t3_hit_cnt_miss", hit_cnt, 2'd1);
`endif

    // Reset to bring the pointer back to 0
    reset = 1'b0;
    #1;
    step();
    reset = 1'b1;

    // Test 4 / 6: all requests held, owners rotate 0,1,2,3,0; counter saturates
    req = 4'b1111; a = 4'b1111; b = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      logic [1:0] exp_owner;
      logic [3:0] exp_gnt;
      exp_owner = 2'(t % 4);
      exp_gnt   = 4'b0001 << exp_owner;
      step();
      $display("t4 txn %0d: gnt=%b owner=%0d", t, gnt, owner);
      chk("t4_gnt", gnt, exp_gnt);
      chk("t4_owner", owner, exp_owner);
      step();
      chk("t4_gnt_b", gnt, exp_gnt);
      step();
      chk("t4_done", done, 1'b1);
      chk("t4_hit", hit, 1'b1);
      step();
      chk("t4_idle_gap", state_var, 2'b00);
      chk("t4_gnt_idle", gnt, 4'b0000);
`ifdef DET_HIT_CNT_EN
      chk("t6_hit_cnt", hit_cnt, (t < 3) ? 32'(t + 1) : 32'd3);
`endif
    end
    req = '0;

    // Test 5: reset during SAMP_B, then pointer restarts at 0
    req = 4'b0010;
    step(); chk("t5_owner_pre", owner, 2'd1);
    step(); chk("t5_samp_b", state_var, 2'b10);
    #2 reset = 1'b0;
    #1;
    chk("t5_state", state_var, 2'b00);
    chk("t5_gnt", gnt, 4'b0000);
    chk("t5_done", done, 1'b0);
    step();
    chk("t5_no_done", done, 1'b0);
    reset = 1'b1; req = 4'b0100;
    step();
    $display("t5 txn: state=%b gnt=%b owner=%0d", state_var, gnt, owner);
    chk("t5_owner", owner, 2'd2);
    chk("t5_gnt_new", gnt, 4'b0100);
    chk("t5_state_a", state_var, 2'b01);
    req = '0;
    step(); step();
    chk("t5_done_end", done, 1'b1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
